// File: rtl/ss_display_if.sv
// Bundle between a seconds source and the two-digit seven-segment driver.
// The source side drives the BCD value, its strobe and the display modes; the driver returns seg/an/err.
interface ss_display_if;
    logic [7:0] ss_in;
    logic       ss_valid;
    logic       blank_lz;
    logic       blink_en;
    logic [6:0] seg;
    logic [1:0] an;
    logic       err;

    modport master (
        output ss_in, ss_valid, blank_lz, blink_en,
        input  seg, an, err
    );

    modport slave (
        input  ss_in, ss_valid, blank_lz, blink_en,
        output seg, an, err
    );
endinterface

// File: rtl/ss_display.sv
// Two-digit multiplexed seven-segment driver for a BCD seconds value, with leading-zero blanking and blink.
// Latency: strobe -> shadow -> seg (two edges); no backpressure, ss_valid is accepted on every cycle.
module ss_display #(
    parameter int SCAN_DIV  = 4,
    parameter int BLINK_DIV = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    ss_display_if.slave bus
);
    localparam int SW = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    typedef enum logic {UNITS = 1'b0, TENS = 1'b1} digit_t;

    logic [SW-1:0] scan_cnt;
    logic [BW-1:0] blink_cnt;
    digit_t        sel;
    logic          phase;
    logic [7:0]    shadow;
    logic          err_q;
    logic [6:0]    seg_q;
    logic [1:0]    an_q;
    logic [6:0]    seg_nxt;
    logic [3:0]    digit;
    logic          in_ok;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h00;
        endcase
    endfunction

    assign in_ok = (bus.ss_in[7:4] <= 4'd5) && (bus.ss_in[3:0] <= 4'd9);
    assign digit = (sel == TENS) ? shadow[7:4] : shadow[3:0];

    // Blink beats error beats blanking; err shows "E" on both digits.
    always_comb begin
        seg_nxt = decode(digit);
        if (bus.blink_en && phase) begin
            seg_nxt = 7'h00;
        end else if (err_q) begin
            seg_nxt = 7'h79;
        end else if (bus.blank_lz && (sel == TENS) && (shadow[7:4] == 4'd0)) begin
            seg_nxt = 7'h00;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_cnt  <= '0;
            blink_cnt <= '0;
            sel       <= UNITS;
            phase     <= 1'b0;
            shadow    <= 8'h00;
            err_q     <= 1'b0;
            seg_q     <= 7'h00;
            an_q      <= 2'b00;
        end else begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                sel      <= (sel == UNITS) ? TENS : UNITS;
            end else begin
                scan_cnt <= scan_cnt + SW'(1);
            end

            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end

            // A rejected value keeps the last good time on the shadow.
            if (bus.ss_valid) begin
                if (in_ok) begin
                    shadow <= bus.ss_in;
                    err_q  <= 1'b0;
                end else begin
                    err_q  <= 1'b1;
                end
            end

            an_q  <= (sel == TENS) ? 2'b10 : 2'b01;
            seg_q <= seg_nxt;
        end
    end

    assign bus.seg = seg_q;
    assign bus.an  = an_q;
    assign bus.err = err_q;
endmodule

// File: tb/tb_ss_display.sv
// Bench for ss_display: directed scenarios plus random strobes against a time-indexed reference model.
module tb_ss_display;
    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 8;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    ss_display_if bus();

    ss_display #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: edges since reset release, last accepted value, error flag.
    int         k;
    logic [7:0] m_shadow;
    logic       m_err;
    logic [6:0] exp_seg;
    logic [1:0] exp_an;
    logic       exp_err;
    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    task automatic model_clear();
        k        = 0;
        m_shadow = 8'h00;
        m_err    = 1'b0;
    endtask

    // Advance one clock; outputs after edge k reflect the digit/phase in force before it.
    task automatic step();
        bit         tens_sel;
        bit         ph;
        logic [3:0] d;
        @(posedge clk);
        k++;
        tens_sel = (((k - 1) / SCAN_DIV) % 2) == 1;
        ph       = (((k - 1) / BLINK_DIV) % 2) == 1;
        exp_an   = tens_sel ? 2'b10 : 2'b01;
        d        = tens_sel ? m_shadow[7:4] : m_shadow[3:0];
        if (bus.blink_en && ph)                                   exp_seg = 7'h00;
        else if (m_err)                                           exp_seg = 7'h79;
        else if (bus.blank_lz && tens_sel && m_shadow[7:4] == 0)  exp_seg = 7'h00;
        else                                                      exp_seg = seg_tab[int'(d)];
        if (bus.ss_valid) begin
            if (bus.ss_in[7:4] <= 4'd5 && bus.ss_in[3:0] <= 4'd9) begin
                m_shadow = bus.ss_in;
                m_err    = 1'b0;
            end else begin
                m_err = 1'b1;
            end
        end
        exp_err = m_err;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_n = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({bus.seg, bus.an, bus.err} !== {7'h00, 2'b00, 1'b0}) begin
            errors++;
            $display("FAIL reset_hold seg/an/err got %h/%b/%b want 00/00/0", bus.seg, bus.an, bus.err);
        end
        release_reset();
        step();
        checks++;
        if ({bus.seg, bus.an, bus.err} !== {7'h3F, 2'b01, 1'b0}) begin
            errors++;
            $display("FAIL reset_first_edge seg/an/err got %h/%b/%b want 3f/01/0", bus.seg, bus.an, bus.err);
        end
    endtask

    task automatic test_scan();
        for (int i = 0; i < 4 * SCAN_DIV; i++) begin
            step();
            checks++;
            if ({bus.seg, bus.an, bus.err} !== {7'h3F, exp_an, 1'b0}) begin
                errors++;
                $display("FAIL scan k=%0d seg/an/err got %h/%b/%b want 3f/%b/0", k, bus.seg, bus.an, bus.err, exp_an);
            end
        end
    endtask

    task automatic test_capture();
        bus.ss_in = 8'h59; bus.ss_valid = 1'b1;
        step();
        bus.ss_valid = 1'b0;
        for (int i = 0; i < 3 * SCAN_DIV; i++) begin
            step();
            checks++;
            if ({bus.seg, bus.an, bus.err} !== {exp_seg, exp_an, exp_err} ||
                bus.seg !== ((exp_an == 2'b01) ? 7'h6F : 7'h6D)) begin
                errors++;
                $display("FAIL capture_59 k=%0d seg/an/err got %h/%b/%b want %h/%b/%b",
                         k, bus.seg, bus.an, bus.err, exp_seg, exp_an, exp_err);
            end
        end
    endtask

    task automatic test_invalid();
        logic [7:0] vals [3] = '{8'h5A, 8'h60, 8'h07};
        for (int v = 0; v < 3; v++) begin
            bus.ss_in = vals[v]; bus.ss_valid = 1'b1;
            step();
            bus.ss_valid = 1'b0;
            for (int i = 0; i < 2 * SCAN_DIV + 1; i++) begin
                step();
                checks++;
                if ({bus.seg, bus.an, bus.err} !== {exp_seg, exp_an, exp_err}) begin
                    errors++;
                    $display("FAIL invalid_%h k=%0d seg/an/err got %h/%b/%b want %h/%b/%b",
                             vals[v], k, bus.seg, bus.an, bus.err, exp_seg, exp_an, exp_err);
                end
            end
        end
        checks++;
        if (m_shadow !== 8'h07 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL invalid_recover err got %b want 0 (model shadow %h)", bus.err, m_shadow);
        end
    endtask

    task automatic test_blank();
        bus.blank_lz = 1'b1;
        for (int i = 0; i < 3 * SCAN_DIV; i++) begin
            step();
            checks++;
            if ({bus.seg, bus.an} !== {((exp_an == 2'b10) ? 7'h00 : 7'h07), exp_an}) begin
                errors++;
                $display("FAIL blank_lz k=%0d seg/an got %h/%b want %h/%b",
                         k, bus.seg, bus.an, exp_seg, exp_an);
            end
        end
        bus.blank_lz = 1'b0;
    endtask

    task automatic test_blink();
        bus.blink_en = 1'b1;
        for (int i = 0; i < 4 * BLINK_DIV; i++) begin
            step();
            checks++;
            if ({bus.seg, bus.an, bus.err} !== {exp_seg, exp_an, exp_err}) begin
                errors++;
                $display("FAIL blink k=%0d seg/an/err got %h/%b/%b want %h/%b/%b",
                         k, bus.seg, bus.an, bus.err, exp_seg, exp_an, exp_err);
            end
        end
        bus.blink_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3 * SCAN_DIV; i++) begin
            bus.ss_in    = {4'(i % 6), 4'((i * 7) % 10)};
            bus.ss_valid = 1'b1;
            step();
            checks++;
            if ({bus.seg, bus.an, bus.err} !== {exp_seg, exp_an, exp_err}) begin
                errors++;
                $display("FAIL back_to_back k=%0d seg/an/err got %h/%b/%b want %h/%b/%b",
                         k, bus.seg, bus.an, bus.err, exp_seg, exp_an, exp_err);
            end
        end
        bus.ss_valid = 1'b0;
    endtask

    task automatic test_random();
        int tens;
        int units;
        for (int i = 0; i < 400; i++) begin
            tens         = $urandom_range(0, 7);
            units        = $urandom_range(0, 11);
            bus.ss_in    = {tens[3:0], units[3:0]};
            bus.ss_valid = ($urandom % 3) == 0;
            if (($urandom % 16) == 0) bus.blink_en = ~bus.blink_en;
            if (($urandom % 16) == 0) bus.blank_lz = ~bus.blank_lz;
            step();
            checks++;
            if ({bus.seg, bus.an, bus.err} !== {exp_seg, exp_an, exp_err}) begin
                errors++;
                $display("FAIL random k=%0d seg/an/err got %h/%b/%b want %h/%b/%b",
                         k, bus.seg, bus.an, bus.err, exp_seg, exp_an, exp_err);
            end
        end
        bus.ss_valid = 1'b0;
        bus.blink_en = 1'b0;
        bus.blank_lz = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.ss_in = 8'h3C; bus.ss_valid = 1'b1;
        step();
        bus.ss_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (bus.err !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_setup err got %b want 1", bus.err);
        end
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.seg, bus.an, bus.err} !== {7'h00, 2'b00, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_async seg/an/err got %h/%b/%b want 00/00/0", bus.seg, bus.an, bus.err);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({bus.seg, bus.an, bus.err} !== {7'h00, 2'b00, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_held seg/an/err got %h/%b/%b want 00/00/0", bus.seg, bus.an, bus.err);
        end
        release_reset();
        for (int i = 0; i < 2 * SCAN_DIV; i++) begin
            step();
            checks++;
            if ({bus.seg, bus.an, bus.err} !== {7'h3F, exp_an, 1'b0}) begin
                errors++;
                $display("FAIL reset_mid_restart k=%0d seg/an/err got %h/%b/%b want 3f/%b/0",
                         k, bus.seg, bus.an, bus.err, exp_an);
            end
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        bus.ss_in    = 8'h00;
        bus.ss_valid = 1'b0;
        bus.blank_lz = 1'b0;
        bus.blink_en = 1'b0;
        model_clear();
        test_reset();
        test_scan();
        test_capture();
        test_invalid();
        test_blank();
        test_blink();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
